// File: rtl/dbus_arbiter.sv
// dbus_arbiter: shares one downstream data bus between the memory-stage
// load/store path (port 0) and an auxiliary master (port 1).
// A grant is held until the owner's dresp_data_ok or until the owner drops
// its valid (flush); every grant is followed by at least one IDLE cycle.
// Optional build macro DBUS_ARB_RR_EN: round-robin tie-break using a
// last_grant register. Without it, port 0 always wins a tie.
//
// state  | meaning
// IDLE   | no owner, downstream request and responses held at 0
// GRANT0 | port 0 owns the bus until data_ok or valid drop
// GRANT1 | port 1 owns the bus until data_ok or valid drop
module dbus_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [2:0]          req0_size,
  input  logic [DATA_W/8-1:0] req0_strobe,
  input  logic [DATA_W-1:0]   req0_data,
  input  logic                req1_valid,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [2:0]          req1_size,
  input  logic [DATA_W/8-1:0] req1_strobe,
  input  logic [DATA_W-1:0]   req1_data,
  output logic                resp0_data_ok,
  output logic [DATA_W-1:0]   resp0_data,
  output logic                resp1_data_ok,
  output logic [DATA_W-1:0]   resp1_data,
  output logic                dreq_valid,
  output logic [ADDR_W-1:0]   dreq_addr,
  output logic [2:0]          dreq_size,
  output logic [DATA_W/8-1:0] dreq_strobe,
  output logic [DATA_W-1:0]   dreq_data,
  input  logic                dresp_data_ok,
  input  logic [DATA_W-1:0]   dresp_data,
  output logic [1:0]          owner
);

  // Encodings double as the debug owner value (00 idle, 01 port0, 10 port1).
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   tie_to_port1;

`ifdef DBUS_ARB_RR_EN
  logic last_grant;

  // Remember which port won the most recent grant; reset to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
    end else if (state == IDLE && state_nxt != IDLE) begin
      last_grant <= (state_nxt == GRANT1);
    end
  end

  assign tie_to_port1 = ~last_grant;
`else
  assign tie_to_port1 = 1'b0;
`endif

  assign owner = state;

  // State register; reset abandons any grant immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: arbitrate in IDLE, release on data_ok or when the owner withdraws.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          state_nxt = tie_to_port1 ? GRANT1 : GRANT0;
        end else if (req0_valid) begin
          state_nxt = GRANT0;
        end else if (req1_valid) begin
          state_nxt = GRANT1;
        end
      end
      GRANT0: begin
        if (dresp_data_ok || !req0_valid) begin
          state_nxt = IDLE;
        end
      end
      GRANT1: begin
        if (dresp_data_ok || !req1_valid) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output steering: the owner's request goes downstream, the response goes only to the owner.
  always_comb begin
    dreq_valid    = 1'b0;
    dreq_addr     = '0;
    dreq_size     = '0;
    dreq_strobe   = '0;
    dreq_data     = '0;
    resp0_data_ok = 1'b0;
    resp0_data    = '0;
    resp1_data_ok = 1'b0;
    resp1_data    = '0;
    case (state)
      GRANT0: begin
        dreq_valid    = req0_valid;
        dreq_addr     = req0_addr;
        dreq_size     = req0_size;
        dreq_strobe   = req0_strobe;
        dreq_data     = req0_data;
        resp0_data_ok = dresp_data_ok;
        resp0_data    = dresp_data;
      end
      GRANT1: begin
        dreq_valid    = req1_valid;
        dreq_addr     = req1_addr;
        dreq_size     = req1_size;
        dreq_strobe   = req1_strobe;
        dreq_data     = req1_data;
        resp1_data_ok = dresp_data_ok;
        resp1_data    = dresp_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Scoreboard bench for dbus_arbiter: stimulus pushes expected downstream
// requests and expected responses; a negedge monitor pops and compares.
module tb_dbus_arbiter;

  localparam logic [2:0] MSIZE4 = 3'd2;
  localparam logic [2:0] MSIZE8 = 3'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [63:0] req0_addr, req1_addr, req0_data, req1_data;
  logic [2:0]  req0_size, req1_size;
  logic [7:0]  req0_strobe, req1_strobe;
  logic        resp0_data_ok, resp1_data_ok;
  logic [63:0] resp0_data, resp1_data;
  logic        dreq_valid;
  logic [63:0] dreq_addr, dreq_data;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic [1:0]  owner;

  dbus_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_size(req0_size),
    .req0_strobe(req0_strobe), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_size(req1_size),
    .req1_strobe(req1_strobe), .req1_data(req1_data),
    .resp0_data_ok(resp0_data_ok), .resp0_data(resp0_data),
    .resp1_data_ok(resp1_data_ok), .resp1_data(resp1_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  own;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strb;
    logic [63:0] data;
  } dreq_t;

  typedef struct {
    int          port;
    logic [63:0] data;
  } resp_t;

  dreq_t dq[$];
  resp_t rq[$];
  int    n_vec = 0;
  int    n_bad = 0;
  bit    model_last = 1'b1;
  logic  prev_v = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare each new downstream grant and each response pulse against the queues.
  always @(negedge clk) begin
    dreq_t e;
    resp_t r;
    int    ap;
    logic [63:0] ad;
    if (reset) begin
      if (dreq_valid && !prev_v) begin
        n_vec++;
        if (dq.size() == 0) begin
          n_bad++;
          $display("FAIL dreq_unexpected: got grant owner=%0d addr=%0h, expected none", owner, dreq_addr);
        end else begin
          e = dq.pop_front();
          if (owner !== e.own || dreq_addr !== e.addr || dreq_size !== e.size ||
              dreq_strobe !== e.strb || dreq_data !== e.data) begin
            n_bad++;
            $display("FAIL dreq: got own=%0d a=%0h s=%0d st=%0h d=%0h expected own=%0d a=%0h s=%0d st=%0h d=%0h",
                     owner, dreq_addr, dreq_size, dreq_strobe, dreq_data,
                     e.own, e.addr, e.size, e.strb, e.data);
          end
        end
      end
      if (resp0_data_ok || resp1_data_ok) begin
        n_vec++;
        ap = resp1_data_ok ? 1 : 0;
        ad = resp1_data_ok ? resp1_data : resp0_data;
        if (rq.size() == 0) begin
          n_bad++;
          $display("FAIL resp_unexpected: got ok0=%0b ok1=%0b, expected no pulse", resp0_data_ok, resp1_data_ok);
        end else begin
          r = rq.pop_front();
          if ((resp0_data_ok && resp1_data_ok) || ap != r.port || ad !== r.data) begin
            n_bad++;
            $display("FAIL resp: got ok0=%0b ok1=%0b data=%0h expected port%0d data=%0h",
                     resp0_data_ok, resp1_data_ok, ad, r.port, r.data);
          end
        end
      end
    end
    prev_v = dreq_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic [63:0] a, input logic [2:0] s,
                         input logic [7:0] st, input logic [63:0] d);
    if (p == 0) begin
      req0_valid = v; req0_addr = a; req0_size = s; req0_strobe = st; req0_data = d;
    end else begin
      req1_valid = v; req1_addr = a; req1_size = s; req1_strobe = st; req1_data = d;
    end
  endtask

  task automatic push_dreq(input int p, input logic [63:0] a, input logic [2:0] s,
                           input logic [7:0] st, input logic [63:0] d);
    dreq_t e;
    e.own = (p == 0) ? 2'b01 : 2'b10;
    e.addr = a; e.size = s; e.strb = st; e.data = d;
    dq.push_back(e);
  endtask

  task automatic push_resp(input int p, input logic [63:0] d);
    resp_t r;
    r.port = p; r.data = d;
    rq.push_back(r);
  endtask

  function automatic int tie_winner();
`ifdef DBUS_ARB_RR_EN
    return model_last ? 0 : 1;
`else
    return 0;
`endif
  endfunction

  // Both ports request together: winner served, one IDLE cycle, then the other.
  task automatic tie_round(input logic [63:0] a0, input logic [63:0] a1,
                           input logic [63:0] r0, input logic [63:0] r1);
    logic [63:0] ta[2];
    logic [63:0] tr[2];
    int w, l;
    ta[0] = a0; ta[1] = a1; tr[0] = r0; tr[1] = r1;
    w = tie_winner();
    l = 1 - w;
    set_req(0, 1'b1, ta[0], MSIZE8, 8'h00, 64'h0);
    set_req(1, 1'b1, ta[1], MSIZE8, 8'h00, 64'h0);
    push_dreq(w, ta[w], MSIZE8, 8'h00, 64'h0);
    push_dreq(l, ta[l], MSIZE8, 8'h00, 64'h0);
    push_resp(w, tr[w]);
    push_resp(l, tr[l]);
    tick();
    model_last = w[0];
    dresp_data_ok = 1'b1; dresp_data = tr[w];
    @(negedge clk);
    check("tie_first_owner", 64'(owner), 64'(w + 1));
    tick();
    set_req(w, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0);
    dresp_data_ok = 1'b0;
    @(negedge clk);
    check("tie_idle_gap", 64'(owner), 64'd0);
    tick();
    model_last = l[0];
    dresp_data_ok = 1'b1; dresp_data = tr[l];
    @(negedge clk);
    check("tie_second_owner", 64'(owner), 64'(l + 1));
    tick();
    set_req(l, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0);
    dresp_data_ok = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    set_req(0, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0);
    set_req(1, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0);
    dresp_data_ok = 1'b0; dresp_data = 64'h0;
    #12;
    check("reset_owner", 64'(owner), 64'd0);
    check("reset_dreq_valid", 64'(dreq_valid), 64'd0);
    reset = 1'b1;

    // Single port-0 load with one cycle of arbitration latency.
    tick();
    set_req(0, 1'b1, 64'h4060_0008, MSIZE8, 8'h00, 64'h0);
    push_dreq(0, 64'h4060_0008, MSIZE8, 8'h00, 64'h0);
    @(negedge clk);
    check("latency_dreq_valid", 64'(dreq_valid), 64'd0);
    tick();
    model_last = 1'b0;
    dresp_data_ok = 1'b1; dresp_data = 64'hDEAD_BEEF;
    push_resp(0, 64'hDEAD_BEEF);
    @(negedge clk);
    check("load_owner", 64'(owner), 64'd1);
    tick();
    set_req(0, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0);
    dresp_data_ok = 1'b0;
    @(negedge clk);
    check("load_owner_after", 64'(owner), 64'd0);

    // Repeated ties.
    tie_round(64'h1000, 64'h2000, 64'hA0, 64'hB0);
    tie_round(64'h1008, 64'h2008, 64'hA1, 64'hB1);

    // Port-1 store in flight when port 0 arrives.
    tick();
    set_req(1, 1'b1, 64'h8000_0010, MSIZE8, 8'hFF, 64'h1122_3344_5566_7788);
    push_dreq(1, 64'h8000_0010, MSIZE8, 8'hFF, 64'h1122_3344_5566_7788);
    tick();
    model_last = 1'b1;
    set_req(0, 1'b1, 64'h4060_0100, MSIZE4, 8'h00, 64'h0);
    push_dreq(0, 64'h4060_0100, MSIZE4, 8'h00, 64'h0);
    @(negedge clk);
    check("store_owner", 64'(owner), 64'd2);
    check("store_resp0_stall", 64'(resp0_data_ok), 64'd0);
    tick();
    @(negedge clk);
    check("store_addr_held", dreq_addr, 64'h8000_0010);
    check("store_data_held", dreq_data, 64'h1122_3344_5566_7788);
    check("store_strobe_held", 64'(dreq_strobe), 64'hFF);
    tick();
    dresp_data_ok = 1'b1; dresp_data = 64'h55;
    push_resp(1, 64'h55);
    @(negedge clk);
    check("store_done_resp0", 64'(resp0_data_ok), 64'd0);
    tick();
    set_req(1, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0);
    dresp_data_ok = 1'b0;
    @(negedge clk);
    check("store_gap_owner", 64'(owner), 64'd0);
    check("store_gap_resp0", 64'(resp0_data_ok), 64'd0);
    tick();
    model_last = 1'b0;
    dresp_data_ok = 1'b1; dresp_data = 64'hCAFE_F00D;
    push_resp(0, 64'hCAFE_F00D);
    @(negedge clk);
    check("waiter_owner", 64'(owner), 64'd1);
    tick();
    set_req(0, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0);
    dresp_data_ok = 1'b0;

    // Flush: port 0 withdraws before data_ok; stray data_ok is dropped.
    tick();
    set_req(0, 1'b1, 64'h4060_0200, MSIZE8, 8'h00, 64'h0);
    push_dreq(0, 64'h4060_0200, MSIZE8, 8'h00, 64'h0);
    tick();
    model_last = 1'b0;
    tick();
    set_req(0, 1'b0, 64'h4060_0200, MSIZE8, 8'h00, 64'h0);
    @(negedge clk);
    check("flush_dreq_drop", 64'(dreq_valid), 64'd0);
    tick();
    dresp_data_ok = 1'b1; dresp_data = 64'hBAD;
    @(negedge clk);
    check("flush_owner", 64'(owner), 64'd0);
    check("stray_resp0", 64'(resp0_data_ok), 64'd0);
    check("stray_resp1", 64'(resp1_data_ok), 64'd0);
    tick();
    dresp_data_ok = 1'b0;

    // Asynchronous reset during a port-1 grant.
    set_req(1, 1'b1, 64'h9000_0000, MSIZE8, 8'h00, 64'h0);
    push_dreq(1, 64'h9000_0000, MSIZE8, 8'h00, 64'h0);
    tick();
    @(negedge clk);
    check("pre_reset_owner", 64'(owner), 64'd2);
    #2;
    reset = 1'b0;
    set_req(1, 1'b0, 64'h0, 3'd0, 8'h00, 64'h0);
    model_last = 1'b1;
    #1;
    check("async_reset_dreq_valid", 64'(dreq_valid), 64'd0);
    check("async_reset_owner", 64'(owner), 64'd0);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("post_reset_idle", 64'(owner), 64'd0);
    end

    check("dreq_queue_empty", 64'(dq.size()), 64'd0);
    check("resp_queue_empty", 64'(rq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Shares the single downstream data bus between two requesters: port 0 is the memory-stage load/store path, port 1 is an auxiliary master such as a page-table walker or cache-maintenance engine.
- Sits between the pipeline's memory stage and the data-side memory interface.
- Grants one requester at a time and holds the grant until that transaction's data_ok.
- Returns the response only to the owner; the other port sees data_ok=0.

Parameters:
- ADDR_W, 64, address width of req addr fields.
- DATA_W, 64, data width; strobe width is DATA_W/8.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous reset, active-low.
- req0_valid  in  1  memory-stage request valid; held stable until resp0_data_ok.
- req0_addr  in  ADDR_W  request address.
- req0_size  in  3  msize encoding (MSIZE1/2/4/8).
- req0_strobe  in  DATA_W/8  byte write strobe; 0 means read.
- req0_data  in  DATA_W  write data.
- req1_valid, req1_addr, req1_size, req1_strobe, req1_data  in  same widths as port 0  auxiliary requester.
- resp0_data_ok  out  1  completion pulse to port 0.
- resp0_data  out  DATA_W  read data to port 0.
- resp1_data_ok, resp1_data  out  1 / DATA_W  completion and read data to port 1.
- dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data  out  1 / ADDR_W / 3 / DATA_W/8 / DATA_W  downstream request.
- dresp_data_ok  in  1  downstream completion.
- dresp_data  in  DATA_W  downstream read data.
- owner  out  2  debug: 00 idle, 01 port0, 10 port1.

Behaviour:
- States are IDLE, GRANT0 and GRANT1, held in a registered state plus grant register. Reset asserted (asynchronously): state=IDLE, owner=00.
- All dreq_* outputs are 0 while in IDLE or while reset is asserted. resp*_data_ok=0 and resp*_data=0 while idle.
- IDLE transitions:
  - Sample req0_valid and req1_valid.
  - Only req0 valid -> GRANT0. Only req1 valid -> GRANT1. Neither valid -> stay in IDLE.
  - Both valid: the fixed-priority winner is port 0 (see Optional Feature).
  - The grant takes effect the next cycle, so there is exactly 1 cycle of arbitration latency from valid to dreq_valid.
- GRANTn:
  - dreq_* = reqn_* combinationally; dreq_valid = reqn_valid.
  - respn_data_ok = dresp_data_ok and respn_data = dresp_data. The non-owner's data_ok is 0.
- Leaving GRANTn:
  - On the cycle dresp_data_ok=1, the next state is IDLE.
  - There is no back-to-back grant, so the other port waits at least one IDLE cycle.
  - If reqn_valid drops before data_ok (pipeline flush), also go to IDLE; any late dresp_data_ok with no owner is dropped.
- dresp_data_ok while in IDLE is ignored; neither resp port pulses.
- A request is never preempted once granted.
- Stall coupling: port 0 sees resp0_data_ok=0 throughout arbitration and any port-1 transaction, so the memory stage naturally stalls (stopm) until its own data_ok.
- reset asserted mid-transaction: the grant is abandoned at once and dreq_valid falls asynchronously. Downstream must tolerate the abort.

Optional Feature:
- DBUS_ARB_RR_EN.
- Defined: round-robin tie-break. A 1-bit last_grant register (reset value 1, so port 0 wins the first tie) is updated on every grant. When both ports are valid in IDLE, the port not granted last wins.
- Undefined: port 0 always wins ties, and last_grant is not implemented.
- Single-requester behaviour is identical with or without the macro.

Test Plan:
- Reset then req0 load:
  - Stimulus: reset deasserted, req0_valid=1, addr=0x40600008, size=MSIZE8.
  - Response: dreq_valid rises 1 cycle later with the same addr. Inject dresp_data_ok with data 0xDEADBEEF -> resp0_data_ok=1, resp0_data=0xDEADBEEF in the same cycle; owner=00 next cycle.
- Simultaneous requests:
  - Stimulus: req0 and req1 valid in the same cycle.
  - Response without DBUS_ARB_RR_EN: port0 served, then after one IDLE cycle port1. With DBUS_ARB_RR_EN and a repeated tie: grants alternate 0,1,0,1.
- Port1 store in flight, req0 arrives:
  - Stimulus: port1 is mid-store (strobe=0xFF) when req0 asserts.
  - Response: resp0_data_ok stays 0 until port1's data_ok plus 1 IDLE cycle plus 1 grant cycle; the port1 store completes unaltered.
- Flush:
  - Stimulus: req0_valid dropped while GRANT0 before data_ok.
  - Response: next cycle IDLE, dreq_valid=0. A stray dresp_data_ok then produces no resp pulse on either port.
- Async reset mid-transaction:
  - Stimulus: assert reset during GRANT1.
  - Response: dreq_valid=0 and owner=00 before the next clock edge. After release, the arbiter stays IDLE with no requests.
